// File: rtl/sqrt_pkg.sv
// Shared types and sizing for the iterative square root unit.
package sqrt_pkg;

  localparam int unsigned SQRT_WIDTH = 32;
  localparam int unsigned SQRT_ITER  = SQRT_WIDTH / 2;
  localparam int unsigned SQRT_CNT_W = $clog2(SQRT_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit iteration: shifts in an operand bit pair and
// resolves one root bit.
module sqrt_step
  import sqrt_pkg::*;
#(
  parameter int unsigned HALF_W = SQRT_ITER
) (
  input  logic [HALF_W+1:0] rem_i,
  input  logic [HALF_W-1:0] root_i,
  input  logic [1:0]        pair_i,
  output logic [HALF_W+1:0] rem_o,
  output logic [HALF_W-1:0] root_o
);

  logic [HALF_W+1:0] rem_sh;
  logic [HALF_W+1:0] trial;

  // Trial subtraction of (root<<2)|1 from the shifted partial remainder.
  always_comb begin
    rem_sh = (rem_i << 2) | {HALF_W'(0), pair_i};
    trial  = {root_i, 2'b01};
    rem_o  = rem_sh;
    root_o = root_i << 1;
    if (rem_sh >= trial) begin
      rem_o  = rem_sh - trial;
      root_o = (root_i << 1) | HALF_W'(1);
    end
  end

endmodule

// File: rtl/square_root_calculator.sv
// Iterative floor(sqrt(TestNumber)), one root bit per clock.
// Optional Remainder/PerfectSquare outputs are built when SQRT_REMAINDER_EN
// is defined.
module square_root_calculator
  import sqrt_pkg::*;
#(
  parameter int unsigned WIDTH = SQRT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] TestNumber,
  output logic             Busy,
  output logic [WIDTH-1:0] SquareRootValue,
  output logic             EnableFromSquareRootCircuit
`ifdef SQRT_REMAINDER_EN
  ,
  output logic [WIDTH/2:0] Remainder,
  output logic             PerfectSquare
`endif
);

  localparam int unsigned ITER  = WIDTH / 2;
  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int unsigned REM_W = ITER + 2;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_chk
    $error("square_root_calculator: WIDTH must be even and at least 4");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_q, op_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [ITER-1:0]    root_q, root_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               en_q, en_d;
  logic [WIDTH-1:0]   sqv_q, sqv_d;
  logic [REM_W-1:0]   rem_next;
  logic [ITER-1:0]    root_next;
`ifdef SQRT_REMAINDER_EN
  logic [ITER:0]      rem_out_q, rem_out_d;
  logic               perfect_q, perfect_d;
`endif

  sqrt_step #(
    .HALF_W (ITER)
  ) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .pair_i (op_q[WIDTH-1 -: 2]),
    .rem_o  (rem_next),
    .root_o (root_next)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state, datapath and output-register next values.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    en_d    = en_q;
    sqv_d   = sqv_q;
`ifdef SQRT_REMAINDER_EN
    rem_out_d = rem_out_q;
    perfect_d = perfect_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = CALC;
          op_d    = TestNumber;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          en_d    = 1'b0;
`ifdef SQRT_REMAINDER_EN
          rem_out_d = '0;
          perfect_d = 1'b0;
`endif
        end
      end
      CALC: begin
        op_d   = op_q << 2;
        rem_d  = rem_next;
        root_d = root_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          en_d    = 1'b1;
          sqv_d   = WIDTH'(root_next);
`ifdef SQRT_REMAINDER_EN
          rem_out_d = rem_next[ITER:0];
          perfect_d = (rem_next == '0);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers; reset discards any partial result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      en_q   <= 1'b0;
      sqv_q  <= '0;
`ifdef SQRT_REMAINDER_EN
      rem_out_q <= '0;
      perfect_q <= 1'b0;
`endif
    end else begin
      op_q   <= op_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      en_q   <= en_d;
      sqv_q  <= sqv_d;
`ifdef SQRT_REMAINDER_EN
      rem_out_q <= rem_out_d;
      perfect_q <= perfect_d;
`endif
    end
  end

  assign Busy                        = busy_q;
  assign EnableFromSquareRootCircuit = en_q;
  assign SquareRootValue             = sqv_q;
`ifdef SQRT_REMAINDER_EN
  assign Remainder     = rem_out_q;
  assign PerfectSquare = perfect_q;
`endif

endmodule

// File: tb/tb_square_root_calculator.sv
// Directed bench for square_root_calculator with a transaction-level model.
module tb_square_root_calculator;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [31:0] TestNumber;
  logic        Busy;
  logic [31:0] SquareRootValue;
  logic        EnableFromSquareRootCircuit;
`ifdef SQRT_REMAINDER_EN
  logic [16:0] Remainder;
  logic        PerfectSquare;
`endif

  int vectors     = 0;
  int miscompares = 0;

  square_root_calculator #(.WIDTH(32)) dut (
    .clk                         (clk),
    .reset                       (reset),
    .Start                       (Start),
    .TestNumber                  (TestNumber),
    .Busy                        (Busy),
    .SquareRootValue             (SquareRootValue),
    .EnableFromSquareRootCircuit (EnableFromSquareRootCircuit)
`ifdef SQRT_REMAINDER_EN
    ,
    .Remainder                   (Remainder),
    .PerfectSquare               (PerfectSquare)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Floor square root by binary search over the root range.
  function automatic longint isqrt(input longint n);
    longint lo, hi, mid;
    lo = 0;
    hi = 65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= n) lo = mid;
      else                hi = mid;
    end
    return lo;
  endfunction

  // Model: accept, count 16 clocks, then publish the root.
  int     m_phase = 0;  // 0 idle, 1 computing, 2 result held
  int     m_cnt   = 0;
  longint m_opnd  = 0;
  longint m_root  = 0;
  longint m_rem   = 0;
  logic   m_busy  = 1'b0;
  logic   m_en    = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0;
      m_busy  <= 1'b0;
      m_en    <= 1'b0;
      m_root  <= 0;
      m_rem   <= 0;
    end else if (m_phase != 1) begin
      if (Start) begin
        m_phase <= 1;
        m_opnd  <= longint'(TestNumber);
        m_cnt   <= 0;
        m_busy  <= 1'b1;
        m_en    <= 1'b0;
      end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 15) begin
        m_phase <= 2;
        m_busy  <= 1'b0;
        m_en    <= 1'b1;
        m_root  <= isqrt(m_opnd);
        m_rem   <= m_opnd - isqrt(m_opnd) * isqrt(m_opnd);
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("busy", 64'(Busy), 64'(m_busy));
    check("enable", 64'(EnableFromSquareRootCircuit), 64'(m_en));
    if (m_en) check("root", 64'(SquareRootValue), 64'(m_root));
    if (reset) check("root_in_reset", 64'(SquareRootValue), 64'd0);
`ifdef SQRT_REMAINDER_EN
    if (m_en) begin
      check("remainder", 64'(Remainder), 64'(m_rem));
      check("perfect", 64'(PerfectSquare), 64'(m_rem == 0));
    end
    if (reset) begin
      check("rem_in_reset", 64'(Remainder), 64'd0);
      check("perfect_in_reset", 64'(PerfectSquare), 64'd0);
    end
`endif
  end

  // Waits (bounded) for Enable; cyc counts edges since the capture edge.
  task automatic wait_enable(inout int cyc);
    while (!EnableFromSquareRootCircuit && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!EnableFromSquareRootCircuit) check("enable_timeout", 64'd0, 64'd1);
  endtask

  task automatic run(input logic [31:0] n, input longint exp_root, input longint exp_rem);
    int cyc;
    Start      = 1'b1;
    TestNumber = n;
    @(posedge clk);
    #1;
    Start = 1'b0;
    check("busy_after_capture", 64'(Busy), 64'd1);
    cyc = 0;
    wait_enable(cyc);
    check("latency", 64'(cyc), 64'd16);
    check("root_literal", 64'(SquareRootValue), 64'(exp_root));
`ifdef SQRT_REMAINDER_EN
    check("rem_literal", 64'(Remainder), 64'(exp_rem));
    check("perfect_literal", 64'(PerfectSquare), 64'(exp_rem == 0));
`else
    if (exp_rem < 0) check("rem_literal_sign", 64'd0, 64'd1);
`endif
  endtask

  initial begin
    int cyc;
    reset      = 1'b1;
    Start      = 1'b1;
    TestNumber = 32'd97;

    check("model_97", 64'(isqrt(97)), 64'd9);
    check("model_144", 64'(isqrt(144)), 64'd12);
    check("model_max", 64'(isqrt(64'h0000_0000_FFFF_FFFF)), 64'd65535);
    check("model_fffe0000", 64'(isqrt(64'h0000_0000_FFFE_0000)), 64'd65534);

    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_busy", 64'(Busy), 64'd0);
      check("reset_enable", 64'(EnableFromSquareRootCircuit), 64'd0);
      check("reset_root", 64'(SquareRootValue), 64'd0);
    end
    Start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_busy", 64'(Busy), 64'd0);

    run(32'd97, 9, 16);
    run(32'd144, 12, 0);
    run(32'd0, 0, 0);
    run(32'd1, 1, 0);
    run(32'hFFFF_FFFF, 65535, 131070);
    run(32'hFFFE_0001, 65535, 0);

    // Start and operand change mid-computation are ignored.
    Start      = 1'b1;
    TestNumber = 32'd97;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    Start      = 1'b1;
    TestNumber = 32'd25;
    cyc = 5;
    wait_enable(cyc);
    check("ignore_latency", 64'(cyc), 64'd16);
    check("ignore_root", 64'(SquareRootValue), 64'd9);
    // Start still high in DONE: accepted on the next edge.
    @(posedge clk);
    #1;
    Start = 1'b0;
    check("done_restart_enable", 64'(EnableFromSquareRootCircuit), 64'd0);
    check("done_restart_busy", 64'(Busy), 64'd1);
    cyc = 0;
    wait_enable(cyc);
    check("restart_latency", 64'(cyc), 64'd16);
    check("restart_root", 64'(SquareRootValue), 64'd5);

    // Reset in the middle of a computation.
    Start      = 1'b1;
    TestNumber = 32'd97;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_busy", 64'(Busy), 64'd0);
    check("midreset_enable", 64'(EnableFromSquareRootCircuit), 64'd0);
    check("midreset_root", 64'(SquareRootValue), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(32'd49, 7, 0);

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
